// File: rtl/test_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : test_arbiter
//  Description : Two-requester, grant-holding bus arbiter (Moore FSM).
//                Requester 0 has fixed priority when both request from idle.
//                The current owner keeps the bus for as long as it holds its
//                request. Grants are one-hot and decoded from the state flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module test_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_GNT0 = 2'b01;
    localparam logic [1:0] c_GNT1 = 2'b10;

    logic [1:0] r_state;
    logic [1:0] w_next_state;

    // State register; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: owner holds while requesting, otherwise hand off
    // directly to the other requester or fall back to idle.
    always_comb begin
        w_next_state = c_IDLE;
        case (r_state)
            c_IDLE: begin
                if (req0) begin
                    w_next_state = c_GNT0;
                end else if (req1) begin
                    w_next_state = c_GNT1;
                end else begin
                    w_next_state = c_IDLE;
                end
            end
            c_GNT0: begin
                if (req0) begin
                    w_next_state = c_GNT0;
                end else if (req1) begin
                    w_next_state = c_GNT1;
                end else begin
                    w_next_state = c_IDLE;
                end
            end
            c_GNT1: begin
                if (req1) begin
                    w_next_state = c_GNT1;
                end else if (req0) begin
                    w_next_state = c_GNT0;
                end else begin
                    w_next_state = c_IDLE;
                end
            end
            // The unused encoding recovers to idle on the next edge.
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Moore outputs: grants depend only on the registered state.
    always_comb begin
        gnt0 = (r_state == c_GNT0);
        gnt1 = (r_state == c_GNT1);
    end

endmodule
`default_nettype wire

// File: tb/tb_test_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_arbiter
//  Description : Self-checking bench for test_arbiter: directed vector table,
//                a mid-cycle sequence, and random traffic against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_arbiter;

    logic clk;
    logic rst;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;

    int checks;
    int errors;

    typedef struct {
        logic rst;
        logic req0;
        logic req1;
        logic exp_gnt0;
        logic exp_gnt1;
    } vec_t;

    vec_t vecs[$];

    test_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare both grants against expected values.
    task automatic check(input string name, input logic e0, input logic e1);
        checks++;
        if (gnt0 !== e0 || gnt1 !== e1) begin
            errors++;
            $display("FAIL %s: got gnt0=%b gnt1=%b, expected gnt0=%b gnt1=%b (t=%0t)",
                     name, gnt0, gnt1, e0, e1, $time);
        end
    endtask

    // Drive inputs away from the edge, clock once, then sample after the edge.
    task automatic step(input logic r, input logic r0, input logic r1);
        @(negedge clk);
        rst  = r;
        req0 = r0;
        req1 = r1;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic r0, input logic r1,
                                input logic e0, input logic e1);
        vec_t v;
        v.rst = r; v.req0 = r0; v.req1 = r1; v.exp_gnt0 = e0; v.exp_gnt1 = e1;
        return v;
    endfunction

    // Reference model: who owns the bus (0 none, 1 requester 0, 2 requester 1).
    function automatic int next_owner(input int owner, input logic r,
                                      input logic r0, input logic r1);
        if (r) return 0;
        if (owner == 1 && r0) return 1;
        if (owner == 2 && r1) return 2;
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    initial begin
        int owner;
        logic r, r0, r1;
        checks = 0;
        errors = 0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;

        // Reset held with both requests high, then release.
        vecs.push_back(mk(1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0));
        // Single requester 0 for 3 cycles.
        vecs.push_back(mk(0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0));
        // Single requester 1 for 3 cycles.
        vecs.push_back(mk(0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0));
        // Contention: no preemption, then direct handoff 0 -> 1.
        vecs.push_back(mk(0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0));
        // Reverse handoff 1 -> 0.
        vecs.push_back(mk(0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0));
        // Simultaneous from idle: 0 wins, 1 pending until 0 drops.
        vecs.push_back(mk(0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0));
        // Mid-ownership reset in GNT1.
        vecs.push_back(mk(0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req0, vecs[i].req1);
            check($sformatf("vec%0d", i), vecs[i].exp_gnt0, vecs[i].exp_gnt1);
        end

        // Grants must not follow requests between edges.
        step(0, 1, 0);
        check("midcyc_grant", 1, 0);
        req0 = 1'b0;
        req1 = 1'b1;
        #3;
        check("midcyc_hold", 1, 0);
        @(posedge clk);
        #1;
        check("midcyc_handoff", 0, 1);

        // Random traffic against the ownership model.
        step(1, 0, 0);
        check("rand_reset", 0, 0);
        owner = 0;
        for (int c = 0; c < 1000; c++) begin
            r  = ($urandom_range(0, 24) == 0);
            r0 = $urandom_range(0, 1);
            r1 = $urandom_range(0, 1);
            step(r, r0, r1);
            owner = next_owner(owner, r, r0, r1);
            check($sformatf("rand%0d", c), owner == 1, owner == 2);
            checks++;
            if (gnt0 && gnt1) begin
                errors++;
                $display("FAIL excl%0d: got gnt0&gnt1=1, expected 0", c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/test_arbiter.md
# test_arbiter

Two-requester, grant-holding bus arbiter implemented as a Moore state machine. Each requester raises a request line and keeps ownership for as long as it holds that request. Priority is fixed: requester 0 wins when both request from idle. The block sits between two bus masters and a shared resource and drives one-hot, registered grant lines.

## Interface
- No parameters.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req0  input  1  request from requester 0; level-sensitive; held high for the whole ownership period.
- req1  input  1  request from requester 1; same semantics as req0.
- gnt0  output  1  grant to requester 0; registered.
- gnt1  output  1  grant to requester 1; registered.

## Operation
- States: IDLE, GNT0, GNT1. Two-bit encoding; the fourth encoding is illegal and recovers to IDLE on the next edge.
- Outputs are a pure function of state:
  - IDLE: gnt0=0, gnt1=0.
  - GNT0: gnt0=1, gnt1=0.
  - GNT1: gnt0=0, gnt1=1.
- gnt0 and gnt1 are never high together.
- Transitions, evaluated at each rising edge when rst=0:
  - IDLE: req0=1 -> GNT0 (req1 ignored). req0=0, req1=1 -> GNT1. Otherwise stay in IDLE.
  - GNT0: req0=1 -> stay in GNT0, with no preemption by req1. req0=0, req1=1 -> GNT1 (direct handoff, no IDLE cycle). Both low -> IDLE.
  - GNT1: req1=1 -> stay in GNT1, with no preemption by req0. req1=0, req0=1 -> GNT0. Both low -> IDLE.
- Reset:
  - rst=1 at a rising edge forces IDLE with gnt0=gnt1=0, regardless of the requests.
  - Reset overrides every transition, including one in the middle of an ownership period.
  - While rst stays high, the arbiter remains in IDLE.
- Inputs are treated as already synchronous to clk. No synchronizers are included.

## Timing
- Request-to-grant latency is 1 cycle. If a request is sampled high at edge N, the grant is high from just after edge N.
- Release latency is 1 cycle. If the owner's request is sampled low at edge N, its grant drops just after edge N.
- On a handoff, the new grant rises in the same cycle the old grant falls. There is no dead cycle and no overlap.
- The first edge with rst=0 after reset evaluates the requests. A request already high at that edge is granted just after it.
- Outputs change only on rising clk edges; no combinational path exists from req to gnt.
- Simultaneous req0 and req1 rising from IDLE: GNT0 is granted. req1 stays pending and is granted only after req0 drops.

## Test plan
- Reset:
  - Stimulus: rst=1 for 2 cycles with req0=req1=1.
  - Required: gnt0=gnt1=0 throughout.
  - Stimulus: release rst with both requests still high.
  - Required: gnt0=1 one edge later.
- Single requester:
  - Stimulus: req0=1 for 3 cycles, then 0.
  - Required: gnt0=1 for exactly 3 cycles, delayed by 1 cycle; gnt1=0 throughout. Repeat with req1 and check gnt1 the same way.
- Contention and hold:
  - Stimulus: req0=1 for 2 cycles, then req0=req1=1 for 2 cycles, then req0=0, req1=1.
  - Required: gnt0 stays 1 through the overlap (no preemption). The edge after req0 drops gives gnt0=0, gnt1=1 in the same cycle.
- Reverse handoff:
  - Stimulus: establish GNT1, then raise req0 while req1 stays high, then drop req1.
  - Required: gnt1 is held until req1 falls, then gnt0=1 on the next edge with no IDLE gap.
- Mid-ownership reset:
  - Stimulus: in GNT1, assert rst=1 for 1 cycle with req1=1.
  - Required: gnt1=0 just after that edge. gnt1 returns 1 at the first edge after rst is released.
- Exclusivity:
  - Stimulus: 1000 cycles of random req0/req1 with occasional rst.
  - Required: gnt0&gnt1 is always 0. Each grant matches a reference model of the transitions above, cycle for cycle.
